// File: rtl/mips32_pkg.sv
// Shared definitions for the five-stage MIPS32-subset core: opcodes, instruction
// classes, instruction field positions and the pipeline register layouts.
package mips32_pkg;

   localparam logic [5:0] OP_ADD    = 6'b000000;
   localparam logic [5:0] OP_SUB    = 6'b000001;
   localparam logic [5:0] OP_AND    = 6'b000010;
   localparam logic [5:0] OP_OR     = 6'b000011;
   localparam logic [5:0] OP_SLT    = 6'b000100;
   localparam logic [5:0] OP_MUL    = 6'b000101;
   localparam logic [5:0] OP_LW     = 6'b001000;
   localparam logic [5:0] OP_SW     = 6'b001001;
   localparam logic [5:0] OP_ADDI   = 6'b001010;
   localparam logic [5:0] OP_SUBI   = 6'b001011;
   localparam logic [5:0] OP_SLTI   = 6'b001100;
   localparam logic [5:0] OP_BNEQZ  = 6'b001101;
   localparam logic [5:0] OP_BEQZ   = 6'b001110;
   localparam logic [5:0] OP_HLT    = 6'b111111;
   // Unassigned opcode used for squashed and reset pipeline slots.
   localparam logic [5:0] OP_BUBBLE = 6'b110000;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_class_e;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] npc;
   } if_id_t;

   typedef struct packed {
      logic [5:0]   op;
      logic [4:0]   dest;
      logic [31:0]  npc;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  imm;
      instr_class_e cls;
   } id_ex_t;

   typedef struct packed {
      logic [4:0]   dest;
      logic [31:0]  aluOut;
      logic [31:0]  b;
      instr_class_e cls;
   } ex_mem_t;

   typedef struct packed {
      logic [4:0]   dest;
      logic [31:0]  aluOut;
      logic [31:0]  lmd;
      instr_class_e cls;
   } mem_wb_t;

   localparam if_id_t  IF_ID_NOP  = '{ir: {OP_BUBBLE, 26'd0}, npc: 32'd0};
   localparam id_ex_t  ID_EX_NOP  = '{op: OP_BUBBLE, dest: 5'd0, npc: 32'd0, a: 32'd0,
                                      b: 32'd0, imm: 32'd0, cls: NOP};
   localparam ex_mem_t EX_MEM_NOP = '{dest: 5'd0, aluOut: 32'd0, b: 32'd0, cls: NOP};
   localparam mem_wb_t MEM_WB_NOP = '{dest: 5'd0, aluOut: 32'd0, lmd: 32'd0, cls: NOP};

   function automatic instr_class_e classify(input logic [5:0] op);
      instr_class_e cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = RR_ALU;
         OP_ADDI, OP_SUBI, OP_SLTI:                     cls = RM_ALU;
         OP_LW:                                         cls = LOAD;
         OP_SW:                                         cls = STORE;
         OP_BNEQZ, OP_BEQZ:                             cls = BRANCH;
         OP_HLT:                                        cls = HALT;
         default:                                       cls = NOP;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for the EX stage; loads and stores reuse the adder for
// address generation.
module mips32_alu
   import mips32_pkg::*;
(
   input  logic [5:0]  i_opcode,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_result
);

   always_comb begin
      o_result = 32'd0;
      case (i_opcode)
         OP_ADD, OP_ADDI, OP_LW, OP_SW: o_result = i_a + i_b;
         OP_SUB, OP_SUBI:               o_result = i_a - i_b;
         OP_AND:                        o_result = i_a & i_b;
         OP_OR:                         o_result = i_a | i_b;
         OP_SLT, OP_SLTI:               o_result = {31'd0, $signed(i_a) < $signed(i_b)};
         OP_MUL:                        o_result = i_a * i_b;
         default:                       o_result = 32'd0;
      endcase
   end

endmodule

// File: rtl/pipelined_mips32.sv
// Five-stage in-order MIPS32-subset core with unified word-addressed memory and
// internal register file; no forwarding or interlocks, branches resolve in EX.
module pipelined_mips32
   import mips32_pkg::*;
#(
   parameter int MEM_WORDS = 1024
) (
   input  logic clk,
   input  logic rst_n,
   output logic halted
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0]  MEM [0:MEM_WORDS-1];
   logic [31:0]  Register [0:31];
   logic [31:0]  PC;
   logic         HALTED;
   logic         BRANCH_TAKEN;

   if_id_t       IF_ID;
   id_ex_t       ID_EX;
   ex_mem_t      EX_MEM;
   mem_wb_t      MEM_WB;

   id_ex_t       w_decoded;
   logic [4:0]   w_rs;
   logic [4:0]   w_rt;
   logic [31:0]  w_aluB;
   logic [31:0]  w_aluResult;
   logic         w_taken;
   logic [31:0]  w_target;
   logic [AW-1:0] w_memAddr;
   logic [31:0]  w_loadData;
   logic         w_memWriteEn;
   logic         w_regWriteEn;
   logic [31:0]  w_wbData;

   assign halted = HALTED;

   // ID: register 0 reads as zero regardless of what the array holds.
   assign w_rs = IF_ID.ir[RS_HI:RS_LO];
   assign w_rt = IF_ID.ir[RT_HI:RT_LO];

   always_comb begin
      w_decoded      = ID_EX_NOP;
      w_decoded.op   = IF_ID.ir[OP_HI:OP_LO];
      w_decoded.cls  = classify(IF_ID.ir[OP_HI:OP_LO]);
      w_decoded.dest = (w_decoded.cls == RR_ALU) ? IF_ID.ir[RD_HI:RD_LO] : w_rt;
      w_decoded.npc  = IF_ID.npc;
      w_decoded.a    = (w_rs == 5'd0) ? 32'd0 : Register[w_rs];
      w_decoded.b    = (w_rt == 5'd0) ? 32'd0 : Register[w_rt];
      w_decoded.imm  = {{16{IF_ID.ir[IMM_HI]}}, IF_ID.ir[IMM_HI:IMM_LO]};
   end

   assign w_aluB = (ID_EX.cls == RR_ALU) ? ID_EX.b : ID_EX.imm;

   mips32_alu u_alu (
      .i_opcode (ID_EX.op),
      .i_a      (ID_EX.a),
      .i_b      (w_aluB),
      .o_result (w_aluResult)
   );

   assign w_taken  = (ID_EX.cls == BRANCH) &&
                     ((ID_EX.op == OP_BEQZ) ? (ID_EX.a == 32'd0) : (ID_EX.a != 32'd0));
   assign w_target = ID_EX.npc + ID_EX.imm;

   // A store right behind HLT is in MEM while HLT retires, so it is blocked too.
   assign w_memAddr    = EX_MEM.aluOut[AW-1:0];
   assign w_loadData   = MEM[w_memAddr];
   assign w_memWriteEn = !HALTED && (MEM_WB.cls != HALT) && (EX_MEM.cls == STORE);
   assign w_regWriteEn = !HALTED && (MEM_WB.dest != 5'd0) &&
                         ((MEM_WB.cls == RR_ALU) || (MEM_WB.cls == RM_ALU) || (MEM_WB.cls == LOAD));
   assign w_wbData     = (MEM_WB.cls == LOAD) ? MEM_WB.lmd : MEM_WB.aluOut;

   always_ff @(posedge clk) begin
      if (w_memWriteEn)
         MEM[w_memAddr] <= EX_MEM.b;
      if (w_regWriteEn)
         Register[MEM_WB.dest] <= w_wbData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PC           <= 32'd0;
         HALTED       <= 1'b0;
         BRANCH_TAKEN <= 1'b0;
         IF_ID        <= IF_ID_NOP;
         ID_EX        <= ID_EX_NOP;
         EX_MEM       <= EX_MEM_NOP;
         MEM_WB       <= MEM_WB_NOP;
      end else if (HALTED) begin
         BRANCH_TAKEN <= 1'b0;
      end else begin
         BRANCH_TAKEN <= w_taken;
         if (MEM_WB.cls == HALT)
            HALTED <= 1'b1;
         MEM_WB <= '{dest: EX_MEM.dest, aluOut: EX_MEM.aluOut, lmd: w_loadData, cls: EX_MEM.cls};
         EX_MEM <= '{dest: ID_EX.dest, aluOut: w_aluResult, b: ID_EX.b, cls: ID_EX.cls};
         if (w_taken) begin
            PC    <= w_target;
            IF_ID <= IF_ID_NOP;
            ID_EX <= ID_EX_NOP;
         end else begin
            PC    <= PC + 32'd1;
            IF_ID <= '{ir: MEM[PC[AW-1:0]], npc: PC + 32'd1};
            ID_EX <= w_decoded;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_mips32.sv
// Directed self-checking bench for pipelined_mips32: small hand-assembled programs
// preloaded during reset, results read back hierarchically.
module tb_pipelined_mips32;

   localparam int MEM_WORDS = 1024;

   localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_AND = 6'b000010;
   localparam logic [5:0] T_OR  = 6'b000011, T_SLT = 6'b000100, T_MUL = 6'b000101;
   localparam logic [5:0] T_LW  = 6'b001000, T_SW  = 6'b001001, T_ADDI = 6'b001010;
   localparam logic [5:0] T_SUBI = 6'b001011, T_SLTI = 6'b001100;
   localparam logic [5:0] T_BNEQZ = 6'b001101, T_BEQZ = 6'b001110;
   localparam logic [31:0] FILL  = 32'hE000_0000;
   localparam logic [31:0] HLT_W = 32'hFC00_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic halted;
   int   testsRun = 0;
   int   testsFailed = 0;
   int   loadAddr = 0;

   pipelined_mips32 #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .halted (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] encR(input logic [5:0] op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] encI(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // Holds the core in reset and wipes memory and registers before a new program.
   task automatic prepare();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) dut.MEM[i] = 32'd0;
      for (int r = 0; r < 32; r++) dut.Register[r] = 32'd0;
      loadAddr = 0;
   endtask

   task automatic put(input logic [31:0] w);
      dut.MEM[loadAddr] = w;
      loadAddr++;
   endtask

   task automatic fillers(input int n);
      for (int i = 0; i < n; i++) put(FILL);
   endtask

   task automatic runUntilHalt(input int budget, output int cycles, output int takenPulses);
      cycles = 0;
      takenPulses = 0;
      @(negedge clk);
      rst_n = 1'b1;
      while (!halted && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (dut.BRANCH_TAKEN) takenPulses++;
      end
   endtask

   task automatic loadAddStoreProgram();
      put(encI(T_ADDI, 1, 0, 120));
      fillers(3);
      put(encI(T_LW, 2, 1, 0));
      fillers(3);
      put(encI(T_ADDI, 2, 2, 45));
      fillers(3);
      put(encI(T_SW, 2, 1, 1));
      put(HLT_W);
      dut.MEM[120] = 32'd100;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      testsRun++;
      if (dut.PC !== 32'd0) begin
         testsFailed++; $display("[TB] FAIL reset_pc: got %0d expected 0", dut.PC);
      end
      testsRun++;
      if (halted !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_halted: got %b expected 0", halted);
      end
      testsRun++;
      if (dut.BRANCH_TAKEN !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL reset_branch_taken: got %b expected 0", dut.BRANCH_TAKEN);
      end
   endtask

   task automatic test_load_add_store();
      int cycles, taken;
      prepare();
      loadAddStoreProgram();
      runUntilHalt(30, cycles, taken);
      testsRun++;
      if (halted !== 1'b1 || cycles != 18) begin
         testsFailed++; $display("[TB] FAIL las_halt: halted=%b after %0d cycles, expected 1 after 18", halted, cycles);
      end
      testsRun++;
      if (dut.MEM[121] !== 32'd145) begin
         testsFailed++; $display("[TB] FAIL las_mem121: got %0d expected 145", dut.MEM[121]);
      end
      testsRun++;
      if (dut.Register[1] !== 32'd120 || dut.Register[2] !== 32'd145) begin
         testsFailed++; $display("[TB] FAIL las_regs: R1=%0d R2=%0d expected 120 145", dut.Register[1], dut.Register[2]);
      end
   endtask

   task automatic test_alu();
      int cycles, taken;
      logic [31:0] got [13];
      logic [31:0] exp [13];
      prepare();
      dut.Register[11] = 32'd99;
      put(encI(T_ADDI, 1, 0, 10));
      put(encI(T_ADDI, 2, 0, 20));
      put(encI(T_ADDI, 3, 0, 25));
      fillers(3);
      put(encR(T_ADD, 4, 2, 3));
      put(encR(T_SUB, 5, 1, 2));
      put(encR(T_AND, 8, 1, 3));
      put(encR(T_OR, 9, 1, 3));
      put(encR(T_SLT, 6, 1, 2));
      put(encR(T_MUL, 7, 1, 2));
      put(encI(T_SLTI, 11, 1, -5));
      put(encI(T_ADDI, 0, 0, 5));
      fillers(3);
      put(encI(T_SLTI, 10, 5, -5));
      put(encR(T_SLT, 12, 5, 1));
      put(HLT_W);
      runUntilHalt(60, cycles, taken);
      testsRun++;
      if (halted !== 1'b1 || cycles != 24) begin
         testsFailed++; $display("[TB] FAIL alu_halt: halted=%b after %0d cycles, expected 1 after 24", halted, cycles);
      end
      exp = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd45, 32'hFFFF_FFF6, 32'd1, 32'd200,
              32'd8, 32'd27, 32'd1, 32'd0, 32'd1};
      for (int r = 0; r < 13; r++) begin
         got[r] = dut.Register[r];
         testsRun++;
         if (got[r] !== exp[r]) begin
            testsFailed++; $display("[TB] FAIL alu_R%0d: got %h expected %h", r, got[r], exp[r]);
         end
      end
   endtask

   task automatic test_branch_loop();
      int cycles, taken;
      prepare();
      dut.MEM[200] = 32'd7;
      put(encI(T_ADDI, 10, 0, 200));
      put(encI(T_ADDI, 2, 0, 1));
      fillers(3);
      put(encI(T_LW, 3, 10, 0));
      fillers(3);
      put(encR(T_MUL, 2, 2, 3));
      put(encI(T_SUBI, 3, 3, 1));
      fillers(3);
      put(encI(T_BNEQZ, 0, 3, -6));
      put(encI(T_ADDI, 20, 20, 1));
      put(encI(T_ADDI, 21, 21, 1));
      put(encI(T_SW, 2, 10, -2));
      put(HLT_W);
      runUntilHalt(300, cycles, taken);
      testsRun++;
      if (halted !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL loop_halt: halted=%b expected 1 after %0d cycles", halted, cycles);
      end
      testsRun++;
      if (dut.MEM[198] !== 32'd5040) begin
         testsFailed++; $display("[TB] FAIL loop_fact: MEM[198]=%0d expected 5040", dut.MEM[198]);
      end
      testsRun++;
      if (dut.Register[20] !== 32'd1 || dut.Register[21] !== 32'd1) begin
         testsFailed++; $display("[TB] FAIL loop_squash: R20=%0d R21=%0d expected 1 1", dut.Register[20], dut.Register[21]);
      end
      testsRun++;
      if (taken != 6) begin
         testsFailed++; $display("[TB] FAIL loop_taken_pulses: got %0d expected 6", taken);
      end
   endtask

   task automatic test_hlt_freeze();
      int cycles, taken;
      prepare();
      dut.Register[9] = 32'd55;
      dut.MEM[50] = 32'd77;
      put(HLT_W);
      put(encI(T_SW, 9, 0, 50));
      put(encI(T_ADDI, 9, 0, 1));
      put(encI(T_ADDI, 9, 0, 2));
      runUntilHalt(20, cycles, taken);
      testsRun++;
      if (halted !== 1'b1 || cycles != 5) begin
         testsFailed++; $display("[TB] FAIL hlt_halt: halted=%b after %0d cycles, expected 1 after 5", halted, cycles);
      end
      for (int i = 0; i < 10; i++) begin
         testsRun++;
         if (dut.PC !== 32'd5 || halted !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL hlt_freeze_pc: cycle %0d PC=%0d halted=%b expected 5 1", i, dut.PC, halted);
         end
         @(negedge clk);
      end
      testsRun++;
      if (dut.Register[9] !== 32'd55) begin
         testsFailed++; $display("[TB] FAIL hlt_r9: got %0d expected 55", dut.Register[9]);
      end
      testsRun++;
      if (dut.MEM[50] !== 32'd77) begin
         testsFailed++; $display("[TB] FAIL hlt_mem50: got %0d expected 77", dut.MEM[50]);
      end
   endtask

   task automatic test_reset_mid_run();
      int cycles, taken;
      prepare();
      loadAddStoreProgram();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      testsRun++;
      if (dut.PC !== 32'd5) begin
         testsFailed++; $display("[TB] FAIL midrst_pc_before: got %0d expected 5", dut.PC);
      end
      #2 rst_n = 1'b0;
      #1;
      testsRun++;
      if (dut.PC !== 32'd0 || halted !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL midrst_assert: PC=%0d halted=%b expected 0 0", dut.PC, halted);
      end
      runUntilHalt(30, cycles, taken);
      testsRun++;
      if (halted !== 1'b1 || cycles != 18 || dut.MEM[121] !== 32'd145) begin
         testsFailed++; $display("[TB] FAIL midrst_rerun: halted=%b cycles=%0d MEM[121]=%0d expected 1 18 145",
                                 halted, cycles, dut.MEM[121]);
      end
      #2 rst_n = 1'b0;
      #1;
      testsRun++;
      if (halted !== 1'b0 || dut.PC !== 32'd0) begin
         testsFailed++; $display("[TB] FAIL midrst_halted_clear: halted=%b PC=%0d expected 0 0", halted, dut.PC);
      end
   endtask

   task automatic test_beqz_not_taken();
      int cycles, taken;
      prepare();
      put(encI(T_ADDI, 1, 0, 3));
      fillers(3);
      put(encI(T_BEQZ, 0, 1, 5));
      put(encI(T_ADDI, 2, 0, 7));
      put(HLT_W);
      fillers(3);
      put(encI(T_ADDI, 2, 0, 99));
      put(HLT_W);
      runUntilHalt(30, cycles, taken);
      testsRun++;
      if (dut.Register[2] !== 32'd7) begin
         testsFailed++; $display("[TB] FAIL beqz_r2: got %0d expected 7", dut.Register[2]);
      end
      testsRun++;
      if (halted !== 1'b1 || cycles != 11 || taken != 0) begin
         testsFailed++; $display("[TB] FAIL beqz_timing: halted=%b cycles=%0d taken=%0d expected 1 11 0",
                                 halted, cycles, taken);
      end
   endtask

   initial begin
      test_reset();
      test_load_add_store();
      test_alu();
      test_branch_loop();
      test_hlt_freeze();
      test_reset_mid_run();
      test_beqz_not_taken();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
